// File: rtl/div_radix2_pkg.sv
// div_radix2_pkg
//   Shared definitions for the radix-2 restoring divider:
//   - div_state_e : FSM state encodings (2 bits)
//   - DIV_RESULT_READY / DIV_RESULT_NOT_READY : levels of ready_out
//   - DIV_START / DIV_STOP : levels of start_i
//   - abs32() : magnitude of a 32-bit operand, optionally treated as signed
package div_radix2_pkg;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  localparam int DIV_W     = 32;
  localparam int DIV_ITERS = 32;

  // Two's-complement magnitude. -0x80000000 wraps to 0x80000000, which is
  // also its correct unsigned magnitude, so no special case is needed.
  function automatic logic [DIV_W-1:0] abs32(input logic neg, input logic [DIV_W-1:0] v);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_radix2.sv
// div_radix2
//   Multi-cycle 32-bit integer divider (restoring, one quotient bit per
//   clock), signed or unsigned. 33-cycle latency from the accepting edge,
//   2 cycles for a zero divisor. Overflow and divide-by-zero give 0-based
//   results, never a trap.
//
// Ports
//   clk       in   1   clock, rising edge
//   rst       in   1   asynchronous reset, active low
//   sign      in   1   1 = signed (DIV), 0 = unsigned (DIVU); sampled on start
//   a         in  32   dividend; sampled on start
//   b         in  32   divisor; sampled on start
//   start_i   in   1   request level, only acted on in FREE
//   annul_i   in   1   abort the running operation
//   result    out 64   {remainder, quotient}; registered, held until next op
//   ready_out out  1   one-cycle pulse, result valid this cycle
module div_radix2
  import div_radix2_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        sign,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result,
  output logic        ready_out
);

  div_state_e  state;
  logic [5:0]  cnt;
  logic [64:0] work;     // {partial remainder[64:32], dividend/quotient[31:0]}
  logic [31:0] bmag;
  logic        sign_r;
  logic        a_neg;
  logic        b_neg;

  // One restoring iteration on the working register.
  logic [64:0] sh;
  logic [33:0] diff;
  logic [64:0] step;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_fin;
  logic [31:0] r_fin;
  logic        start_ok;

  always_comb begin
    sh   = work << 1;
    // 34-bit difference so the borrow lands in bit 33 even when the
    // shifted remainder uses its full 33 bits.
    diff = {1'b0, sh[64:32]} - {2'b00, bmag};
    step = sh;
    if (!diff[33]) step = {diff[32:0], sh[31:1], 1'b1};
    // Remainder is always below the divisor magnitude, so 32 bits suffice.
    q_mag = step[31:0];
    r_mag = step[63:32];
    // Quotient is negative when operand signs differ; the remainder
    // follows the dividend. 0x80000000 / -1 has equal signs and wraps.
    q_fin = (sign_r && (a_neg ^ b_neg)) ? (~q_mag + 32'd1) : q_mag;
    r_fin = (sign_r && a_neg)           ? (~r_mag + 32'd1) : r_mag;
    // Annul outranks start in FREE.
    start_ok = (start_i == DIV_START) && !annul_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= DIV_FREE;
      result    <= '0;
      ready_out <= DIV_RESULT_NOT_READY;
      cnt       <= '0;
      work      <= '0;
      bmag      <= '0;
      sign_r    <= 1'b0;
      a_neg     <= 1'b0;
      b_neg     <= 1'b0;
    end else begin
      case (state)
        DIV_FREE: begin
          ready_out <= DIV_RESULT_NOT_READY;
          if (start_ok) begin
            if (b == 32'd0) begin
              state <= DIV_BYZERO;
            end else begin
              state  <= DIV_ON;
              work   <= {33'd0, abs32(sign && a[31], a)};
              bmag   <= abs32(sign && b[31], b);
              sign_r <= sign;
              a_neg  <= sign && a[31];
              b_neg  <= sign && b[31];
              cnt    <= '0;
            end
          end
        end

        DIV_BYZERO: begin
          result    <= '0;
          ready_out <= DIV_RESULT_READY;
          state     <= DIV_END;
        end

        DIV_ON: begin
          if (annul_i) begin
            state  <= DIV_FREE;
            result <= '0;
            cnt    <= '0;
          end else begin
            work <= step;
            cnt  <= cnt + 6'd1;
            // The 32nd iteration's output goes straight into result so that
            // result and ready_out are both registered in END.
            if (cnt == 6'(DIV_ITERS - 1)) begin
              state     <= DIV_END;
              result    <= {r_fin, q_fin};
              ready_out <= DIV_RESULT_READY;
            end
          end
        end

        DIV_END: begin
          // start_i seen here is ignored; it is picked up next cycle in FREE.
          ready_out <= DIV_RESULT_NOT_READY;
          state     <= DIV_FREE;
        end

        default: begin
          ready_out <= DIV_RESULT_NOT_READY;
          state     <= DIV_FREE;
        end
      endcase
    end
  end

endmodule
